// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register reader.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RSTART,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_STOP
  } state_t;

  // Which byte the write path is currently sending.
  typedef enum logic [1:0] {
    B_ADDR_W,
    B_REG,
    B_ADDR_R
  } wr_sel_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider: pulses o_qtick every CLK_DIV clk and advances a 2-bit phase.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_stall,
  output logic       o_qtick,
  output logic [1:0] o_phase
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;
  logic          w_term;

  assign w_term  = (r_cnt == CW'(CLK_DIV - 1));
  // A stall holds the divider at its last count so the quarter ends as soon as it lifts.
  assign o_qtick = i_en && w_term && !i_stall;
  assign o_phase = r_phase;

  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt   <= '0;
      r_phase <= 2'd0;
    end else if (w_term) begin
      if (!i_stall) begin
        r_cnt   <= '0;
        r_phase <= r_phase + 2'd1;
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_reg_reader.sv
// I2C master performing START/addr+W/reg/RSTART/addr+R/N bytes/STOP register reads.
// Optional slave clock stretching is enabled with I2C_CLOCK_STRETCH_EN.
module i2c_reg_reader
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 125,
  parameter int MAX_BYTES = 4,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             dev_addr,
  input  logic [7:0]             reg_addr,
  input  logic [NB_W-1:0]        num_bytes,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic [8*MAX_BYTES-1:0] rd_data,
  inout  wire                    scl,
  inout  wire                    sda
);

  localparam int DATA_W = 8 * MAX_BYTES;

  state_t            r_state;
  wr_sel_t           r_sel;
  logic [2:0]        r_bit;
  logic [7:0]        r_tx;
  logic [7:0]        r_rx;
  logic              r_nack;
  logic [NB_W-1:0]   r_left;
  logic [6:0]        r_dev;
  logic [7:0]        r_reg;
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_scl_low;
  logic              r_sda_low;
  logic              r_busy;
  logic              r_done;
  logic              r_ack_err;

  logic              w_en;
  logic              w_stall;
  logic              w_qtick;
  logic [1:0]        w_phase;
  logic              w_sda_in;
  logic [NB_W-1:0]   w_nb;

  assign scl      = r_scl_low ? 1'b0 : 1'bz;
  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign w_sda_in = sda;
  assign w_en     = (r_state != ST_IDLE);

  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rd_data = r_rd_data;

`ifdef I2C_CLOCK_STRETCH_EN
  logic [1:0] r_scl_sync;

  always_ff @(posedge clk) begin
    if (reset) r_scl_sync <= 2'b11;
    else       r_scl_sync <= {r_scl_sync[0], scl};
  end

  assign w_stall = (w_phase == Q1) && !r_scl_sync[1];
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    if (num_bytes == '0)                     w_nb = NB_W'(1);
    else if (num_bytes > NB_W'(MAX_BYTES))   w_nb = NB_W'(MAX_BYTES);
    else                                     w_nb = num_bytes;
  end

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en),
    .i_stall (w_stall),
    .o_qtick (w_qtick),
    .o_phase (w_phase)
  );

  // Output updates at each tick describe the quarter being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sel     <= B_ADDR_W;
      r_bit     <= 3'd0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_nack    <= 1'b0;
      r_left    <= '0;
      r_dev     <= 7'd0;
      r_reg     <= 8'd0;
      r_shadow  <= '0;
      r_rd_data <= '0;
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start && !r_done) begin
          r_state   <= ST_START;
          r_busy    <= 1'b1;
          r_ack_err <= 1'b0;
          r_dev     <= dev_addr;
          r_reg     <= reg_addr;
          r_left    <= w_nb;
          r_shadow  <= '0;
        end
      end else if (w_qtick) begin
        if (w_phase == Q0) r_scl_low <= 1'b0;
        if (w_phase == Q2 && r_state != ST_STOP) r_scl_low <= 1'b1;

        unique case (r_state)
          ST_IDLE: ;
          ST_START: begin
            if (w_phase == Q0) r_sda_low <= 1'b1;
            if (w_phase == Q3) begin
              r_state   <= ST_WR_BYTE;
              r_sel     <= B_ADDR_W;
              r_bit     <= 3'd0;
              r_tx      <= {r_dev, I2C_WRITE};
              r_sda_low <= ~r_dev[6];
            end
          end
          ST_WR_BYTE: begin
            if (w_phase == Q3) begin
              if (r_bit == 3'd7) begin
                r_state   <= ST_WR_ACK;
                r_sda_low <= 1'b0;
              end else begin
                r_bit     <= r_bit + 3'd1;
                r_tx      <= {r_tx[6:0], 1'b0};
                r_sda_low <= ~r_tx[6];
              end
            end
          end
          ST_WR_ACK: begin
            if (w_phase == Q1) r_nack <= w_sda_in;
            if (w_phase == Q3) begin
              r_bit <= 3'd0;
              if (r_nack) begin
                r_ack_err <= 1'b1;
                r_state   <= ST_STOP;
                r_sda_low <= 1'b1;
              end else begin
                unique case (r_sel)
                  B_ADDR_W: begin
                    r_state   <= ST_WR_BYTE;
                    r_sel     <= B_REG;
                    r_tx      <= r_reg;
                    r_sda_low <= ~r_reg[7];
                  end
                  B_REG:    r_state <= ST_RSTART;
                  B_ADDR_R: r_state <= ST_RD_BYTE;
                  default:  r_state <= ST_STOP;
                endcase
              end
            end
          end
          ST_RSTART: begin
            if (w_phase == Q1) r_sda_low <= 1'b1;
            if (w_phase == Q3) begin
              r_state   <= ST_WR_BYTE;
              r_sel     <= B_ADDR_R;
              r_bit     <= 3'd0;
              r_tx      <= {r_dev, I2C_READ};
              r_sda_low <= ~r_dev[6];
            end
          end
          ST_RD_BYTE: begin
            if (w_phase == Q1) r_rx <= {r_rx[6:0], w_sda_in};
            if (w_phase == Q3) begin
              if (r_bit == 3'd7) begin
                r_state   <= ST_RD_ACK;
                r_shadow  <= (r_shadow << 8) | DATA_W'(r_rx);
                r_sda_low <= (r_left > NB_W'(1));
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (w_phase == Q3) begin
              r_bit <= 3'd0;
              if (r_left > NB_W'(1)) begin
                r_left    <= r_left - NB_W'(1);
                r_state   <= ST_RD_BYTE;
                r_sda_low <= 1'b0;
              end else begin
                r_state   <= ST_STOP;
                r_sda_low <= 1'b1;
              end
            end
          end
          ST_STOP: begin
            if (w_phase == Q1) r_sda_low <= 1'b0;
            if (w_phase == Q3) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              if (!r_ack_err) r_rd_data <= r_shadow;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_reader.sv
// Scoreboard bench for i2c_reg_reader with a bit-level I2C slave and a register-file reference.
module tb_i2c_reg_reader;

  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 4;
  localparam int NB_W      = $clog2(MAX_BYTES + 1);
  localparam logic [6:0] SLV = 7'h48;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [6:0]             dev_addr;
  logic [7:0]             reg_addr;
  logic [NB_W-1:0]        num_bytes;
  logic                   busy, done, ack_err;
  logic [8*MAX_BYTES-1:0] rd_data;
  wire                    scl, sda;

  pullup (scl);
  pullup (sda);

  logic s_sda_drv = 1'b0;
  logic s_scl_hold = 1'b0;
  assign sda = s_sda_drv ? 1'b0 : 1'bz;
  assign scl = s_scl_hold ? 1'b0 : 1'bz;

  i2c_reg_reader #(
    .CLK_DIV   (CLK_DIV),
    .MAX_BYTES (MAX_BYTES),
    .NB_W      (NB_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dev_addr  (dev_addr),
    .reg_addr  (reg_addr),
    .num_bytes (num_bytes),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .rd_data   (rd_data),
    .scl       (scl),
    .sda       (sda)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          nacks;
    int          pat;
    int          starts;
    int          stops;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [256];
  logic [31:0] last_rd = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slave at SLV: register pointer write, then sequential reads from mem.
  typedef enum {SL_IDLE, SL_ADDR, SL_REG, SL_WAIT, SL_READ} sl_t;
  sl_t        sl_st = SL_IDLE;
  int         bitcnt = 0;
  logic [7:0] sh, tx, ptr;
  logic       rw, last_ack;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         n_start = 0, n_stop = 0;
  logic       acks[$];
  int         run_len = 0;
  bit         hi_ok = 0, lo_ok = 0;
  int         hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
  int         stretch_cnt = 0;
  bit         stretch_pending = 1'b0;

  task automatic slave_step();
    logic b_scl, b_sda;
    b_scl = scl;
    b_sda = sda;
    if (reset) begin
      sl_st = SL_IDLE; s_sda_drv = 0; s_scl_hold = 0; stretch_cnt = 0;
      hi_ok = 0; lo_ok = 0; run_len = 0;
      prev_scl = b_scl; prev_sda = b_sda;
      return;
    end
    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) s_scl_hold = 0;
    end
    if (b_scl == prev_scl) run_len++;
    else begin
      if (b_scl && lo_ok) begin
        if (run_len < lo_min) lo_min = run_len;
        if (run_len > lo_max) lo_max = run_len;
      end
      if (!b_scl && hi_ok) begin
        if (run_len < hi_min) hi_min = run_len;
        if (run_len > hi_max) hi_max = run_len;
      end
      hi_ok = b_scl; lo_ok = !b_scl; run_len = 1;
    end
    if (b_scl && prev_scl && prev_sda && !b_sda) begin
      n_start++; sl_st = SL_ADDR; bitcnt = -1; sh = '0;
    end else if (b_scl && prev_scl && !prev_sda && b_sda) begin
      n_stop++; sl_st = SL_IDLE; s_sda_drv = 0; hi_ok = 0;
    end
    if (b_scl && !prev_scl && sl_st != SL_IDLE) begin
      if (bitcnt >= 0 && bitcnt < 8 && (sl_st == SL_ADDR || sl_st == SL_REG))
        sh = {sh[6:0], b_sda};
      if (bitcnt == 8 && sl_st == SL_READ) begin
        last_ack = b_sda;
        acks.push_back(b_sda);
      end
    end
    if (!b_scl && prev_scl && sl_st != SL_IDLE) begin
      bitcnt++;
      if (bitcnt == 8) begin
        s_sda_drv = 0;
        if (sl_st == SL_ADDR) begin
          if (sh[7:1] == SLV) begin s_sda_drv = 1; rw = sh[0]; end
          else sl_st = SL_IDLE;
        end else if (sl_st == SL_REG) begin
          s_sda_drv = 1; ptr = sh;
        end
      end else if (bitcnt == 9) begin
        bitcnt = 0; s_sda_drv = 0;
        if (sl_st == SL_ADDR) begin
          if (stretch_pending) begin
            stretch_pending = 0; s_scl_hold = 1; stretch_cnt = 50;
          end
          if (rw) begin
            sl_st = SL_READ; tx = mem[ptr]; ptr = ptr + 8'd1; s_sda_drv = !tx[7];
          end else sl_st = SL_REG;
        end else if (sl_st == SL_REG) begin
          sl_st = SL_WAIT;
        end else if (sl_st == SL_READ) begin
          if (!last_ack) begin
            tx = mem[ptr]; ptr = ptr + 8'd1; s_sda_drv = !tx[7];
          end else sl_st = SL_IDLE;
        end
      end else if (sl_st == SL_READ && bitcnt >= 1 && bitcnt <= 7) begin
        s_sda_drv = !tx[7-bitcnt];
      end
    end
    prev_scl = b_scl;
    prev_sda = b_sda;
  endtask

  always @(negedge clk) slave_step();

  // Monitor: each done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1, required no done");
      end else begin
        exp_t e;
        int   act_pat;
        e = sb.pop_front();
        act_pat = 0;
        foreach (acks[i]) act_pat = (act_pat << 1) | int'(acks[i]);
        check("ack_err", 64'(ack_err), 64'(e.err));
        check("rd_data", 64'(rd_data), 64'(e.data));
        check("master_ack_count", 64'(acks.size()), 64'(e.nacks));
        check("master_ack_pattern", 64'(act_pat), 64'(e.pat));
        check("start_count", 64'(n_start), 64'(e.starts));
        check("stop_count", 64'(n_stop), 64'(e.stops));
      end
    end
  end

  task automatic issue(input logic [6:0] da, input logic [7:0] ra, input logic [NB_W-1:0] nb);
    exp_t e;
    int   n;
    n = (nb == 0) ? 1 : ((int'(nb) > MAX_BYTES) ? MAX_BYTES : int'(nb));
    e.stops = 1;
    if (da == SLV) begin
      e.err = 0; e.data = '0;
      for (int i = 0; i < n; i++) e.data = (e.data << 8) | 32'(mem[8'(ra + i)]);
      e.nacks = n; e.pat = 1; e.starts = 2;
      last_rd = e.data;
    end else begin
      e.err = 1; e.data = last_rd; e.nacks = 0; e.pat = 0; e.starts = 1;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    n_start = 0; n_stop = 0; acks.delete();
    start = 1; dev_addr = da; reg_addr = ra; num_bytes = nb;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: got no done in 4000 cycles, required a done pulse");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_txn(input logic [6:0] da, input logic [7:0] ra, input logic [NB_W-1:0] nb,
                         input bit poke);
    issue(da, ra, nb);
    if (poke) begin
      repeat (40) @(posedge clk);
      #1 start = 1; dev_addr = ~da; num_bytes = 1;
      @(posedge clk); #1 start = 0;
    end
    wait_done();
  endtask

  initial begin
    logic [6:0] da;
    bit         seen;
    reset = 1; start = 0; dev_addr = '0; reg_addr = '0; num_bytes = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[1] = 8'h19;
    mem[2] = 8'h80;
`ifdef I2C_CLOCK_STRETCH_EN
    stretch_pending = 1'b1;
`endif
    repeat (4) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ack_err", 64'(ack_err), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_scl", 64'(scl), 64'(1));
    check("rst_sda", 64'(sda), 64'(1));

    run_txn(SLV, 8'h01, 3'd2, 0);
    run_txn(7'h27, 8'h05, 3'd2, 0);
    run_txn(SLV, 8'h20, 3'd0, 1);
    run_txn(SLV, 8'h30, 3'd7, 0);

    // Abort mid-read with reset.
    issue(SLV, 8'h10, 3'd4);
    seen = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (sl_st == SL_READ && bitcnt == 3) begin seen = 1; break; end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL reach_rd_byte: got no read phase, required one");
    end
    @(posedge clk); #1 reset = 1;
    void'(sb.pop_back());
    last_rd = '0;
    @(negedge clk);
    @(negedge clk);
    check("abort_scl", 64'(scl), 64'(1));
    check("abort_sda", 64'(sda), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(posedge clk); #1 reset = 0;
    repeat (3) @(posedge clk);
    run_txn(SLV, 8'h40, 3'd3, 0);

    for (int t = 0; t < 10; t++) begin
      da = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      if ($urandom_range(0, 3) == 0 && da == SLV) da = SLV ^ 7'h01;
      run_txn(da, 8'($urandom), NB_W'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    end

`ifndef I2C_CLOCK_STRETCH_EN
    check("scl_high_min", 64'(hi_min), 64'(2 * CLK_DIV));
    check("scl_high_max", 64'(hi_max), 64'(2 * CLK_DIV));
    check("scl_low_min", 64'(lo_min), 64'(2 * CLK_DIV));
    check("scl_low_max", 64'(lo_max), 64'(2 * CLK_DIV));
`endif
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_reg_reader.md
Name: i2c_reg_reader

Overview:
- Parametrised I2C master that performs a complete register read: START, address+W, register pointer, repeated START, address+R, then N data bytes, then STOP.
- Device address, register address and byte count are per-transaction inputs; the result is returned on a wide output with a done/error handshake.
- Sits between the sensor-polling control logic and the board I2C pins; open-drain drive on both SCL and SDA.

Parameters:
- CLK_DIV, 125, clk cycles per quarter SCL period (SCL period = 4*CLK_DIV clk); must be >= 2.
- MAX_BYTES, 4, maximum data bytes per read (1..8).
- NB_W, $clog2(MAX_BYTES+1), width of num_bytes (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- dev_addr  in  7  7-bit slave address, latched on accepted start
- reg_addr  in  8  register pointer, latched on accepted start
- num_bytes  in  NB_W  bytes to read, latched on accepted start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of transaction
- ack_err  out  1  valid with done; 1 = slave NACKed address or register byte
- rd_data  out  8*MAX_BYTES  received bytes, right-aligned, first byte most significant
- scl  inout  1  open-drain; driven 0 or released (z)
- sda  inout  1  open-drain; driven 0 or released (z)

Behaviour:
- Reset: busy=0, done=0, ack_err=0, rd_data=0, SCL and SDA released, state IDLE, divider cleared. Reset mid-transaction aborts immediately with no STOP.
- Quarter tick from divider; each bit spans Q0..Q3.
  - Q0: SCL low; SDA updated at Q0 entry.
  - Q1, Q2: SCL released.
  - Q3: SCL low.
  - SDA sampled at the Q1->Q2 boundary.
- States: IDLE, START, WR_BYTE, WR_ACK, RSTART, RD_BYTE, RD_ACK, STOP.
- IDLE -> START on start: latch inputs; busy rises next cycle. num_bytes=0 is treated as 1; values above MAX_BYTES are clamped to MAX_BYTES.
- START: SDA pulled low while SCL high for 2 quarters, then SCL low.
- WR_BYTE: 8 bits MSB first. First byte = {dev_addr,0}; second byte = reg_addr.
- WR_ACK: SDA released; sampled 0 = ACK.
  - After the address byte -> WR_BYTE (reg_addr).
  - After the reg byte -> RSTART.
  - Sampled 1 -> ack_err latched, go to STOP.
- RSTART:
  - Q0: SCL low, SDA released.
  - Q1: SCL high.
  - Q2: SDA low.
  - Q3: SCL low.
  - Then WR_BYTE with {dev_addr,1}; its ACK leads to RD_BYTE.
- RD_BYTE: SDA released; 8 samples shifted in MSB first. rd_data shadow is shifted left 8 and the byte is inserted at [7:0].
- RD_ACK: master drives 0 (ACK) if more bytes remain, releases (NACK) after the last byte; then RD_BYTE or STOP.
- STOP:
  - Q0: SCL low, SDA low.
  - Q1: SCL released.
  - Q2: SDA released.
  - Q3: bus idle.
- Completion, one cycle after Q3 of STOP:
  - done=1 for 1 cycle; busy=0.
  - rd_data updated from the shadow on success, with unused upper bytes zero.
  - On error, rd_data holds its previous value.
- start while busy is ignored. start in the same cycle as done is ignored; accepted from the following cycle.
- ack_err holds until the next accepted start.
- Bus lines are never driven high.

Optional Feature:
- Macro I2C_CLOCK_STRETCH_EN.
- Defined:
  - scl input synchronised via 2 flops.
  - In Q1 the divider freezes while synchronised scl reads 0, i.e. the slave stretches.
  - Q2 begins only after scl is seen high.
- Undefined: scl input ignored; timing purely counter-driven.

Decomposition:
- Package i2c_pkg:
  - State enum.
  - Quarter-phase constants Q0..Q3.
  - RW bit constants I2C_WRITE=0, I2C_READ=1.
- Sub-module i2c_quarter_tick: divider producing qtick and a 2-bit phase, with a stall input used by the stretch feature.

Test Plan:
- dev_addr=0x48, reg_addr=0x01, num_bytes=2; slave model returns 0x19, 0x80 -> rd_data=0x00001980, ack_err=0, master ACKs byte 1, NACKs byte 2, STOP seen, done pulse.
- No slave at 0x27 (address NACK) -> no reg byte, STOP, done with ack_err=1, rd_data unchanged.
- num_bytes=0 -> exactly 1 byte read, then NACK. num_bytes=7 with MAX_BYTES=4 -> 4 bytes read, rd_data = the 4 bytes big-endian.
- CLK_DIV=4 -> SCL high and low each 8 clk. Check START/RSTART/STOP SDA edges occur only while SCL high, and data changes only while SCL low.
- reset asserted during RD_BYTE -> next cycle SCL/SDA released, busy=0, no done. A new start afterwards completes normally.
- With I2C_CLOCK_STRETCH_EN, slave holds SCL low 50 clk after the address ACK -> bit timing is extended by exactly the stretch, and data is still correct.
